// File: rtl/regfile32_if.sv
// regfile32 bus: one write port, two combinational read ports.
// master drives indices/write data; slave returns read data.
interface regfile32_if;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  modport master (
    output we,
    output waddr,
    output wdata,
    output raddr1,
    output raddr2,
    input  rdata1,
    input  rdata2
  );

  modport slave (
    input  we,
    input  waddr,
    input  wdata,
    input  raddr1,
    input  raddr2,
    output rdata1,
    output rdata2
  );
endinterface

// File: rtl/regfile32.sv
// regfile32: 31x32 storage (r0 hard-wired zero), sync write, comb read.
// Optional macro REGFILE_BYPASS_EN forwards write data to matching reads.
module regfile32 (
  input logic        clk,
  input logic        rst_n,
  regfile32_if.slave bus
);

  logic [31:0] regs [1:31];
  logic [31:1] wdec;
  logic [31:0] rmux [32];
  logic [31:0] rd1;
  logic [31:0] rd2;

  // one-hot write select; index 0 has no storage so it is never decoded
  always_comb begin
    wdec = '0;
    for (int i = 1; i < 32; i++) begin
      wdec[i] = bus.we && (bus.waddr == 5'(i));
    end
  end

  // storage: reset clears everything and drops a coincident write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wdec[i]) begin
          regs[i] <= bus.wdata;
        end
      end
    end
  end

  // 32-entry read source table with r0 tied to zero
  always_comb begin
    rmux[0] = '0;
    for (int i = 1; i < 32; i++) begin
      rmux[i] = regs[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;

  // write-through: forward only for a live, non-r0 write outside reset
  always_comb begin
    fwd_ok = rst_n && bus.we && (bus.waddr != 5'd0);
    rd1 = rmux[bus.raddr1];
    rd2 = rmux[bus.raddr2];
    if (fwd_ok && (bus.raddr1 == bus.waddr)) begin
      rd1 = bus.wdata;
    end
    if (fwd_ok && (bus.raddr2 == bus.waddr)) begin
      rd2 = bus.wdata;
    end
  end
`else
  // plain read muxes: old contents until the write edge
  always_comb begin
    rd1 = rmux[bus.raddr1];
    rd2 = rmux[bus.raddr2];
  end
`endif

  assign bus.rdata1 = rd1;
  assign bus.rdata2 = rd2;

endmodule

// File: tb/tb_regfile32.sv
// tb_regfile32: random + directed stimulus, array reference model,
// queue scoreboard compared by an independent monitor process.
module tb_regfile32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  regfile32_if bus();

  regfile32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } chk_t;

  chk_t        q[$];
  logic [31:0] model [32];
  int          checks = 0;
  int          failures = 0;
  bit          done = 1'b0;

  function automatic logic [31:0] expect_rd(
    input logic        r,
    input logic        w,
    input logic [4:0]  wa,
    input logic [31:0] wd,
    input logic [4:0]  a
  );
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (r && w && (wa == a)) return wd;
`endif
    return model[a];
  endfunction

  task automatic step(
    input logic        r,
    input logic        w,
    input logic [4:0]  wa,
    input logic [31:0] wd,
    input logic [4:0]  a1,
    input logic [4:0]  a2,
    input string       tag
  );
    chk_t c;
    rst_n      = r;
    bus.we     = w;
    bus.waddr  = wa;
    bus.wdata  = wd;
    bus.raddr1 = a1;
    bus.raddr2 = a2;
    c.tag = tag;
    c.a1  = a1;
    c.a2  = a2;
    c.e1  = expect_rd(r, w, wa, wd, a1);
    c.e2  = expect_rd(r, w, wa, wd, a2);
    q.push_back(c);
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (w && (wa != 5'd0)) begin
      model[wa] = wd;
    end
    #1;
  endtask

  // monitor: read ports are combinational, so sample mid-cycle
  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      c = q.pop_front();
      checks++;
      if (bus.rdata1 !== c.e1) begin
        failures++;
        $display("FAIL %s port1 addr=%0d got=%h exp=%h",
                 c.tag, c.a1, bus.rdata1, c.e1);
      end
      checks++;
      if (bus.rdata2 !== c.e2) begin
        failures++;
        $display("FAIL %s port2 addr=%0d got=%h exp=%h",
                 c.tag, c.a2, bus.rdata2, c.e2);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    bus.we = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.raddr1 = '0;
    bus.raddr2 = '0;
    @(posedge clk);
    #1;

    // first reset: contents unknown, only r0 is defined
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "rst0");
    for (int a = 0; a < 32; a++)
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), "rstval");

    // fill, then reset clears everything
    for (int i = 1; i < 32; i++)
      step(1'b1, 1'b1, 5'(i), 32'hDEAD0000 + i, 5'(i), 5'd0, "fill");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd31, "rstclr");
    for (int a = 0; a < 32; a++)
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), "clrsweep");

    // r0 immutable
    step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "r0pre");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "r0post");

    // full sweep
    for (int i = 1; i < 32; i++)
      step(1'b1, 1'b1, 5'(i), 32'hDEAD0000 + i, 5'd0, 5'(i), "sweepw");
    for (int a = 0; a < 32; a++)
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), "sweepr");

    // read-during-write on r5
    step(1'b1, 1'b1, 5'd5, 32'h1111, 5'd0, 5'd0, "r5init");
    step(1'b1, 1'b1, 5'd5, 32'h2222, 5'd5, 5'd5, "rdwpre");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "rdwpost");

    // reset beats write, no forwarding during reset
    step(1'b1, 1'b1, 5'd7, 32'h77, 5'd0, 5'd0, "r7init");
    step(1'b0, 1'b1, 5'd7, 32'hCAFEBABE, 5'd7, 5'd7, "rstwpre");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, "rstwpost");

    // back-to-back writes to r9
    step(1'b1, 1'b1, 5'd9, 32'hA, 5'd9, 5'd0, "b2b_n");
    step(1'b1, 1'b1, 5'd9, 32'hB, 5'd9, 5'd9, "b2b_n1");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, "b2b_n2");

    // random traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      logic        r;
      logic        w;
      logic [4:0]  wa;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] wd;
      r  = ($urandom_range(0, 31) != 0);
      w  = ($urandom_range(0, 3) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step(r, w, wa, wd, a1, a2, "rand");
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1);
    end
  end

endmodule
